// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue block: opcode encodings, op field bit positions,
// issue FSM state encoding and the queued command record.
package alu_pkg;

    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_SUB     = 3'b001;
    localparam logic [2:0] OP_ILLEGAL = 3'b010;
    localparam logic [2:0] OP_MUL     = 3'b011;
    localparam logic [2:0] OP_CMP0    = 3'b100;
    localparam logic [2:0] OP_CMP1    = 3'b101;
    localparam logic [2:0] OP_CMP2    = 3'b110;
    localparam logic [2:0] OP_DIV     = 3'b111;

    localparam int unsigned FLOAT_BIT  = 3;
    localparam int unsigned SIGNED_BIT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2,
        HALT  = 2'd3
    } state_e;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } cmd_t;

    // 010 is illegal regardless of the float/signed qualifier bits.
    function automatic logic op_legal(input logic [4:0] op);
        return op[2:0] != OP_ILLEGAL;
    endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Command queue for alu_issue: DEPTH entries of {op, a, b} plus tag, wrapping pointers
// and an occupancy count from which full/empty are derived.
module alu_issue_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  cmd_t             push_cmd_i,
    input  logic [TAG_W-1:0] push_tag_i,
    input  logic             pop_i,
    output cmd_t             head_cmd_o,
    output logic [TAG_W-1:0] head_tag_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    cmd_t             cmd_mem_q [DEPTH];
    logic [TAG_W-1:0] tag_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

    // Full is taken from the registered count, so a pop never frees room in the same cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    assign head_cmd_o = cmd_mem_q[rd_ptr_q];
    assign head_tag_o = tag_mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            cmd_mem_q[wr_ptr_q] <= push_cmd_i;
            tag_mem_q[wr_ptr_q] <= push_tag_i;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Handshaked multi-cycle front end for the combinational ALU: queues commands, holds operands
// for SETTLE cycles, captures the result. Define ALU_ISSUE_ZE_HALT_EN to halt after a ze response.
module alu_issue
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [4:0]       cmd_op,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [31:0]      alu_instr,
    input  logic [31:0]      alu_s,
    input  logic             alu_ze,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_s,
    output logic             rsp_ze,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic             halted,
    input  logic             halt_clr
);

    localparam int unsigned CNT_W = $clog2(SETTLE + 1);

    cmd_t             head_cmd;
    logic [TAG_W-1:0] head_tag;
    logic             fifo_full, fifo_empty, fifo_pop;
    cmd_t             push_cmd;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [4:0]       alu_op_q, alu_op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_s_q, rsp_s_d;
    logic             rsp_ze_q, rsp_ze_d;
    logic             rsp_err_q, rsp_err_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic             halt_pend_q, halt_pend_d;
    logic             issue;

    assign push_cmd = '{op: cmd_op, a: cmd_a, b: cmd_b};

    alu_issue_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_fifo (
        .clk_i      (clk),
        .rst_i      (rst),
        .push_i     (cmd_valid),
        .push_cmd_i (push_cmd),
        .push_tag_i (cmd_tag),
        .pop_i      (fifo_pop),
        .head_cmd_o (head_cmd),
        .head_tag_o (head_tag),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign cmd_ready = ~fifo_full;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_instr = {27'b0, alu_op_q};
    assign rsp_valid = rsp_valid_q;
    assign rsp_s     = rsp_s_q;
    assign rsp_ze    = rsp_ze_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_tag   = rsp_tag_q;
    assign busy      = ~fifo_empty | (state_q != IDLE);

`ifdef ALU_ISSUE_ZE_HALT_EN
    assign halted = (state_q == HALT);
`else
    assign halted = 1'b0;
    logic unused_halt_clr;
    assign unused_halt_clr = halt_clr;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        tag_d       = tag_q;
        rsp_valid_d = rsp_valid_q;
        rsp_s_d     = rsp_s_q;
        rsp_ze_d    = rsp_ze_q;
        rsp_err_d   = rsp_err_q;
        rsp_tag_d   = rsp_tag_q;
        halt_pend_d = halt_pend_q;
        issue       = 1'b0;
        fifo_pop    = 1'b0;

        unique case (state_q)
            IDLE: begin
                issue = ~fifo_empty;
            end
            DRIVE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_s_d     = alu_s;
                    rsp_ze_d    = alu_ze;
                    rsp_err_d   = 1'b0;
                    rsp_tag_d   = tag_q;
                    state_d     = RESP;
`ifdef ALU_ISSUE_ZE_HALT_EN
                    halt_pend_d = alu_ze;
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (halt_pend_q) begin
                        halt_pend_d = 1'b0;
                        state_d     = HALT;
                    end else if (!fifo_empty) begin
                        issue = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HALT: begin
`ifdef ALU_ISSUE_ZE_HALT_EN
                if (halt_clr) begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        // Shared pop/load path for IDLE and for a handoff in RESP.
        if (issue) begin
            fifo_pop = 1'b1;
            if (op_legal(head_cmd.op)) begin
                alu_a_d  = head_cmd.a;
                alu_b_d  = head_cmd.b;
                alu_op_d = head_cmd.op;
                tag_d    = head_tag;
                cnt_d    = CNT_W'(SETTLE);
                state_d  = DRIVE;
            end else begin
                rsp_valid_d = 1'b1;
                rsp_s_d     = '0;
                rsp_ze_d    = 1'b0;
                rsp_err_d   = 1'b1;
                rsp_tag_d   = head_tag;
                state_d     = RESP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            tag_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_s_q     <= '0;
            rsp_ze_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_tag_q   <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_s_q     <= rsp_s_d;
            rsp_ze_q    <= rsp_ze_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tag_q   <= rsp_tag_d;
            halt_pend_q <= halt_pend_d;
        end
    end

endmodule
